apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester that sits directly upstream of apb_slave and drives its psel/penable/paddr/pwrite/pwdata, consuming prdata/pready.
- Converts a simple valid/ready command interface from local control logic into compliant two-phase APB transfers (SETUP then ACCESS).
- Returns one response per command, including read data and a wait-state timeout error.

Parameters:
ADDR_WIDTH, 4, width of cmd_addr/paddr
DATA_WIDTH, 8, width of write/read data
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept command (high only in IDLE)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  DATA_WIDTH  read data (valid with rsp_valid on reads)
rsp_err  out  1  with rsp_valid: transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready from slave

Behaviour:
- Reset (preset=1 at a pclk edge): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, wait counter all 0. Reset overrides everything, including mid-transfer: psel/penable drop on the very next edge, no rsp_valid generated for the aborted transfer.
- All outputs registered except cmd_ready = (state==IDLE) && !preset.
- States: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0. On cmd_valid && cmd_ready: latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata; next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; next state ACCESS unconditionally.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable for the whole transfer.
  - pready=1: transfer completes. Next cycle: state=IDLE, psel=0, penable=0, rsp_valid=1, rsp_err=0, rsp_rdata=prdata if read, else rsp_rdata holds its previous value.
  - pready=0: wait counter increments. If TIMEOUT!=0 and counter reaches TIMEOUT (i.e. TIMEOUT cycles of pready low in ACCESS), abort: next cycle state=IDLE, psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready=1 on the same cycle the counter reaches TIMEOUT: completion wins, rsp_err=0.
- Wait counter clears on entry to SETUP; width clog2(TIMEOUT+1), minimum 1; saturates, never wraps.
- Latency: zero-wait write/read is accepted at edge N, SETUP N+1, ACCESS N+2, rsp_valid N+3. Minimum command spacing 3 cycles; no back-to-back from ACCESS.
- rsp_valid is a single-cycle pulse, cleared the next cycle. rsp_rdata/rsp_err hold until the next response.
- paddr/pwdata/pwrite retain their last values in IDLE; they change only on command acceptance.
- cmd_valid while busy: ignored, no state change; the requester must hold the command until cmd_ready.

Decomposition:
- Shared package apb_pkg: state enum (IDLE/SETUP/ACCESS), default ADDR_WIDTH/DATA_WIDTH constants, shared by apb_slave and apb_master.
- One natural sub-module: apb_wait_timer (enable, clear, TIMEOUT param, expired output), reusable by slave-side wait logic.

Test Plan:
- Write: cmd write addr=5 wdata=220, slave pready=1 -> SETUP with psel=1/penable=0, then ACCESS with paddr=5, pwdata=220, pwrite=1; rsp_valid pulse 3 cycles after accept, rsp_err=0.
- Read-back: cmd read addr=5 after the write -> pwrite=0 in SETUP/ACCESS, rsp_rdata=220 with rsp_valid.
- Wait states: slave holds pready=0 for 3 ACCESS cycles -> penable stays 1, addr/data stable, rsp_valid 6 cycles after accept, rsp_err=0.
- Timeout: TIMEOUT=16, pready tied 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; cmd_ready high the following cycle.
- Reset mid-ACCESS: preset=1 while pready=0 -> next edge psel=penable=0, all outputs 0, no rsp_valid; a new command after reset completes normally.
- Busy backpressure: cmd_valid held high with addr=3 during an active transfer -> cmd_ready=0 and no re-latch; addr=3 is accepted only on return to IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and default bus widths
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 4;
  localparam int APB_DATA_WIDTH = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating wait-state counter with timeout flag
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SAT  = CW'((TIMEOUT == 0) ? 1 : TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the cycle that would be the TIMEOUT-th low-ready cycle, so the
  // abort lands on the following edge.
  assign expired_o = (TIMEOUT != 0) && en_i && (count_q >= LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command to two-phase APB requester
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  apb_state_e            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  accept;
  logic                  wait_en;
  logic                  expired;

  assign cmd_ready = (state_q == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign wait_en   = (state_q == ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (pclk),
    .rst_i     (preset),
    .en_i      (wait_en),
    .clr_i     (accept),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!pwrite_q) begin
            rsp_rdata_d = prdata;
          end
        end else if (expired) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

  localparam int TIMEOUT = 16;

  logic       pclk;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  apb_master #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks the outstanding command and how many
  // cycles it has been in flight, sampled between clock edges.
  initial begin : model
    logic       m_active, m_write, m_rsp_valid, m_err, started;
    logic [3:0] m_addr;
    logic [7:0] m_wdata, m_rdata;
    int         m_age, m_lows;
    m_active = 0; m_write = 0; m_rsp_valid = 0; m_err = 0; started = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_age = 0; m_lows = 0;
    forever begin
      @(negedge pclk);
      if (started) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_active && !preset));
        chk("psel",      32'(psel),      32'(m_active));
        chk("penable",   32'(penable),   32'(m_active && m_age >= 2));
        chk("pwrite",    32'(pwrite),    32'(m_write));
        chk("paddr",     32'(paddr),     32'(m_addr));
        chk("pwdata",    32'(pwdata),    32'(m_wdata));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_err",   32'(rsp_err),   32'(m_err));
      end
      if (preset) begin
        m_active = 0; m_write = 0; m_rsp_valid = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_age = 0; m_lows = 0;
        started = 1;
      end else begin
        m_rsp_valid = 0;
        if (!m_active) begin
          if (cmd_valid) begin
            m_active = 1; m_age = 1; m_lows = 0;
            m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
          end
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (pready) begin
          m_active = 0; m_rsp_valid = 1; m_err = 0;
          if (!m_write) m_rdata = prdata;
        end else begin
          m_lows++;
          m_age++;
          if (TIMEOUT != 0 && m_lows >= TIMEOUT) begin
            m_active = 0; m_rsp_valid = 1; m_err = 1; m_rdata = 0;
          end
        end
      end
    end
  end

  // Issues one command; the slave holds pready low for the first nwait
  // ACCESS cycles. lat counts cycles from accept to the response cycle.
  task automatic run_cmd(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input int nwait, input logic nv, input logic [3:0] na,
                         output int lat, output int acc);
    int k;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    prdata = mem[a]; pready = 1'b0;
    k = 0;
    @(negedge pclk);
    while (!cmd_ready && k < 50) begin
      @(negedge pclk);
      k++;
    end
    if (!cmd_ready) chk("accept_wait", 32'(0), 32'(1));
    @(posedge pclk); #1;
    cmd_valid = nv; cmd_addr = na; cmd_write = 1'b0;
    lat = 1; acc = 0;
    while (lat < 100) begin
      @(posedge pclk); #1;
      lat++;
      if (rsp_valid) break;
      if (psel) chk("paddr_stable", 32'(paddr), 32'(a));
      if (penable) begin
        acc++;
        pready = (acc > nwait);
      end
    end
    if (!rsp_valid) chk("rsp_wait", 32'(0), 32'(1));
    if (w && !rsp_err) mem[a] = d;
  endtask

  initial begin : stim
    int lat, acc, k;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i * 3);
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 0;
    cmd_wdata = 0; prdata = 0; pready = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", 32'(psel), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rdata", 32'(rsp_rdata), 32'(0));
    preset = 1'b0;
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'(1));

    run_cmd(1'b1, 4'd5, 8'd220, 0, 1'b0, 4'd0, lat, acc);
    chk("wr_latency", 32'(lat), 32'(3));
    chk("wr_err", 32'(rsp_err), 32'(0));
    chk("wr_paddr_kept", 32'(paddr), 32'(5));
    chk("wr_pwdata_kept", 32'(pwdata), 32'(220));
    chk("wr_pwrite_kept", 32'(pwrite), 32'(1));

    run_cmd(1'b0, 4'd5, 8'd0, 0, 1'b0, 4'd0, lat, acc);
    chk("rd_latency", 32'(lat), 32'(3));
    chk("rd_data", 32'(rsp_rdata), 32'(220));
    chk("rd_pwrite", 32'(pwrite), 32'(0));

    run_cmd(1'b1, 4'd2, 8'h3C, 3, 1'b0, 4'd0, lat, acc);
    chk("wait_latency", 32'(lat), 32'(6));
    chk("wait_access", 32'(acc), 32'(4));
    chk("wait_err", 32'(rsp_err), 32'(0));
    chk("wait_rdata_held", 32'(rsp_rdata), 32'(220));

    run_cmd(1'b0, 4'd2, 8'd0, 2, 1'b0, 4'd0, lat, acc);
    chk("wait_rd_data", 32'(rsp_rdata), 32'h3C);

    run_cmd(1'b1, 4'd1, 8'h5A, 15, 1'b0, 4'd0, lat, acc);
    chk("edge_latency", 32'(lat), 32'(18));
    chk("edge_access", 32'(acc), 32'(16));
    chk("edge_err", 32'(rsp_err), 32'(0));

    run_cmd(1'b0, 4'd4, 8'd0, 1000, 1'b0, 4'd0, lat, acc);
    chk("to_latency", 32'(lat), 32'(18));
    chk("to_access", 32'(acc), 32'(16));
    chk("to_err", 32'(rsp_err), 32'(1));
    chk("to_rdata", 32'(rsp_rdata), 32'(0));
    chk("to_psel", 32'(psel), 32'(0));
    @(posedge pclk); #1;
    chk("to_ready_after", 32'(cmd_ready), 32'(1));
    chk("to_pulse_cleared", 32'(rsp_valid), 32'(0));

    run_cmd(1'b1, 4'd7, 8'h11, 2, 1'b1, 4'd3, lat, acc);
    chk("bp_first_latency", 32'(lat), 32'(5));
    run_cmd(1'b0, 4'd3, 8'd0, 0, 1'b0, 4'd0, lat, acc);
    chk("bp_second_latency", 32'(lat), 32'(3));
    chk("bp_second_paddr", 32'(paddr), 32'(3));
    chk("bp_second_rdata", 32'(rsp_rdata), 32'h49);

    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd9; cmd_wdata = 8'h99; pready = 1'b0;
    k = 0;
    @(negedge pclk);
    while (!cmd_ready && k < 50) begin
      @(negedge pclk);
      k++;
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("mid_penable", 32'(penable), 32'(1));
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rst_psel", 32'(psel), 32'(0));
    chk("mid_rst_penable", 32'(penable), 32'(0));
    chk("mid_rst_paddr", 32'(paddr), 32'(0));
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    preset = 1'b0;
    @(posedge pclk); #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    run_cmd(1'b0, 4'd5, 8'd0, 1, 1'b0, 4'd0, lat, acc);
    chk("post_rst_latency", 32'(lat), 32'(4));
    chk("post_rst_rdata", 32'(rsp_rdata), 32'(220));

    repeat (2) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
